// File: rtl/alu_multicycle.sv
// alu_multicycle -- RV32/RV64-style R-type ALU with an optional iterative
// multiply/divide unit.
//
// Build option: define ALU_MULDIV_EN to add the M-extension ops
// (funct7 = 0000001). The BUSY state and the shift-add / restoring-divide
// datapath exist only in that build. Without it, those encodings are
// illegal and every op completes in one cycle.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    request handshake; in_ready is high only in IDLE
//   subfunction_3/_7       funct3 / funct7 of the R-type instruction
//   input_register1_value  rs1 operand (XLEN)
//   input_register2_value  rs2 operand (XLEN)
//   out_valid / out_ready  result handshake
//   result_to_write_rd     rd result (XLEN), valid while out_valid
//   error                  illegal encoding, valid while out_valid
//   dbg_state              current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The request is captured on that edge, so the inputs may change
// afterwards. Once out_valid is high, the result and error stay stable until
// out_valid && out_ready. The cycle after that handshake is IDLE, so a new
// request can never be accepted in the same cycle as a result is drained.
module alu_multicycle #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      subfunction_3,
  input  logic [6:0]      subfunction_7,
  input  logic [XLEN-1:0] input_register1_value,
  input  logic [XLEN-1:0] input_register2_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_to_write_rd,
  output logic            error,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MULDIV_EN
    S_BUSY = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]    rs1, rs2;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               alu_err;
  logic               is_md;
  logic               accept;

  assign rs1      = input_register1_value;
  assign rs2      = input_register2_value;
  assign shamt    = rs2[SHAMT_W-1:0];
  assign in_ready = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept   = in_valid && in_ready;
  assign dbg_state = state;

  // Single-cycle ops. These are evaluated on the live inputs and registered
  // on accept, so the captured result is what the request asked for.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    is_md   = 1'b0;
    case (subfunction_7)
      7'b0000000: begin
        case (subfunction_3)
          3'b000:  alu_res = rs1 + rs2;
          3'b001:  alu_res = rs1 << shamt;
          3'b010:  alu_res = XLEN'($signed(rs1) < $signed(rs2));
          3'b011:  alu_res = XLEN'(rs1 < rs2);
          3'b100:  alu_res = rs1 ^ rs2;
          3'b101:  alu_res = rs1 >> shamt;
          3'b110:  alu_res = rs1 | rs2;
          default: alu_res = rs1 & rs2;
        endcase
      end
      7'b0100000: begin
        case (subfunction_3)
          3'b000:  alu_res = rs1 - rs2;
          3'b101:  alu_res = $unsigned($signed(rs1) >>> shamt);
          default: alu_err = 1'b1;
        endcase
      end
`ifdef ALU_MULDIV_EN
      7'b0000001: is_md = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CNT_W = $clog2(XLEN);

  // Both the multiply and the divide work on magnitudes. The sign is fixed
  // up once, after the last step. {acc_hi, acc_lo} is the running product,
  // or {remainder, dividend/quotient}.
  logic [2:0]        md_op;
  logic              md_neg;    // negate the product or the quotient
  logic              md_rneg;   // negate the remainder (dividend sign)
  logic              md_bzero;  // divisor was zero
  logic [XLEN-1:0]   md_a;      // original rs1, returned by REM/REMU on /0
  logic [XLEN-1:0]   md_b;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [CNT_W-1:0]  cnt;
  logic              last_step;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  // MUL takes the low half, which does not depend on signedness, so it is
  // run as unsigned. MULHSU treats only rs1 as signed.
  assign a_sgn = subfunction_3[2] ? ~subfunction_3[0]
                                  : (subfunction_3 == 3'b001 || subfunction_3 == 3'b010);
  assign b_sgn = subfunction_3[2] ? ~subfunction_3[0] : (subfunction_3 == 3'b001);
  assign a_neg = a_sgn & rs1[XLEN-1];
  assign b_neg = b_sgn & rs2[XLEN-1];
  assign a_mag = a_neg ? ('0 - rs1) : rs1;
  assign b_mag = b_neg ? ('0 - rs2) : rs2;
  assign last_step = (cnt == CNT_W'(XLEN - 1));

  logic [XLEN:0]     sum, shifted, diff;
  logic [XLEN-1:0]   hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, md_final;

  // One iteration: a shift-add multiply step or a restoring divide step.
  always_comb begin
    hi_n    = acc_hi;
    lo_n    = acc_lo;
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_b} : '0);
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, md_b};
    if (md_op[2]) begin
      if (!diff[XLEN]) begin
        hi_n = diff[XLEN-1:0];
        lo_n = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = shifted[XLEN-1:0];
        lo_n = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // Sign fix-up and the special cases. The most-negative / -1 overflow
  // needs no special case: the magnitude quotient 2^(XLEN-1) with a positive
  // sign already equals rs1, and the remainder is 0.
  always_comb begin
    prod     = {hi_n, lo_n};
    prod_s   = md_neg ? ('0 - prod) : prod;
    quo      = md_neg ? ('0 - lo_n) : lo_n;
    rem      = md_rneg ? ('0 - hi_n) : hi_n;
    md_final = '0;
    case (md_op)
      3'b000:        md_final = prod_s[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:        md_final = prod_s[2*XLEN-1:XLEN];
      3'b100,
      3'b101:        md_final = md_bzero ? '1 : quo;
      default:       md_final = md_bzero ? md_a : rem;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_op    <= '0;
      md_neg   <= 1'b0;
      md_rneg  <= 1'b0;
      md_bzero <= 1'b0;
      md_a     <= '0;
      md_b     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
    end else if (accept && is_md) begin
      md_op    <= subfunction_3;
      md_neg   <= a_neg ^ b_neg;
      md_rneg  <= a_neg;
      md_bzero <= (rs2 == '0);
      md_a     <= rs1;
      acc_hi   <= '0;
      cnt      <= '0;
      if (subfunction_3[2]) begin
        md_b   <= b_mag;
        acc_lo <= a_mag;
      end else begin
        md_b   <= a_mag;
        acc_lo <= b_mag;
      end
    end else if (state == S_BUSY) begin
      acc_hi <= hi_n;
      acc_lo <= lo_n;
      cnt    <= cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) state_nxt = is_md ? state_t'(2'd1) : S_DONE;
      end
`ifdef ALU_MULDIV_EN
      S_BUSY: begin
        if (last_step) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      result_to_write_rd <= '0;
      error              <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && !is_md) begin
        result_to_write_rd <= alu_res;
        error              <= alu_err;
      end
`ifdef ALU_MULDIV_EN
      else if (state == S_BUSY && last_step) begin
        result_to_write_rd <= md_final;
        error              <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        in_valid, in_ready, out_valid, out_ready, error;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rs1, rs2, res;
  logic [1:0]  dbg;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, error8;
  logic [2:0]  f3_8;
  logic [6:0]  f7_8;
  logic [7:0]  a8, b8, res8;
  logic [1:0]  dbg8;

  alu_multicycle #(.XLEN(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .subfunction_3(f3), .subfunction_7(f7),
    .input_register1_value(rs1), .input_register2_value(rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_to_write_rd(res), .error(error), .dbg_state(dbg)
  );

  alu_multicycle #(.XLEN(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .subfunction_3(f3_8), .subfunction_7(f7_8),
    .input_register1_value(a8), .input_register2_value(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .result_to_write_rd(res8), .error(error8), .dbg_state(dbg8)
  );

`ifdef ALU_MULDIV_EN
  localparam int MD_LAT = 33;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];

  // Reference model for the single-cycle ops.
  function automatic void model(input logic [2:0] mf3, input logic [6:0] mf7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    r = 32'h0;
    e = 1'b0;
    if (mf7 == 7'h00) begin
      case (mf3)
        3'd0: r = a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (mf7 == 7'h20 && mf3 == 3'd0) begin
      r = a - b;
    end else if (mf7 == 7'h20 && mf3 == 3'd5) begin
      r = 32'($signed(a) >>> b[4:0]);
    end else begin
      e = 1'b1;
    end
  endfunction

  // Driver: issue one request on the 32-bit DUT, scramble the inputs after
  // accept, wait (bounded) for the result, then drain it.
  task automatic run32(input logic [2:0] tf3, input logic [6:0] tf7,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e, output int lat,
                       output logic rdy);
    @(negedge clk);
    rdy = in_ready;
    in_valid = 1'b1; f3 = tf3; f7 = tf7; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    f3 = 3'($urandom); f7 = 7'($urandom); rs1 = $urandom; rs2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res;
    e = error;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run8(input logic [2:0] tf3, input logic [6:0] tf7,
                      input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] r, output logic e, output int lat);
    @(negedge clk);
    in_valid8 = 1'b1; f3_8 = tf3; f7_8 = tf7; a8 = a; b8 = b;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!out_valid8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res8;
    e = error8;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; f3 = '0; f7 = '0; rs1 = '0; rs2 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; f3_8 = '0; f7_8 = '0; a8 = '0; b8 = '0;
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || error !== 1'b0 || res !== 32'h0) begin
      bad++;
      $display("FAIL reset32: rdy=%b vld=%b err=%b res=%h want 1 0 0 00000000",
               in_ready, out_valid, error, res);
    end
    total++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || error8 !== 1'b0 || res8 !== 8'h0) begin
      bad++;
      $display("FAIL reset8: rdy=%b vld=%b err=%b res=%h want 1 0 0 00",
               in_ready8, out_valid8, error8, res8);
    end
    // First accept on the first rising edge with reset released.
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1; f3 = 3'd0; f7 = 7'h00; rs1 = 32'd2; rs2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || res !== 32'd5) begin
      bad++;
      $display("FAIL first_accept: vld=%b res=%h want 1 00000005", out_valid, res);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0]  vf3;
    logic [6:0]  vf7;
    logic [31:0] va, vb, ve, r, er;
    logic        e, ee, rdy;
    int          lat, el;
    for (int i = 0; i < 28; i++) begin
      vf3 = 3'd0; vf7 = 7'h00; va = 32'h0; vb = 32'h0; ve = 32'h0;
      case (i)
        0: begin vf7 = 7'h20; va = 32'd5; vb = 32'd7; ve = 32'hFFFFFFFE; end
        1: begin vf3 = 3'd5; vf7 = 7'h20; va = 32'h80000000; vb = 32'h24; ve = 32'hF8000000; end
        2: begin vf3 = 3'd3; va = 32'd1; vb = 32'hFFFFFFFF; ve = 32'd1; end
        3: begin vf3 = 3'd2; va = 32'd1; vb = 32'hFFFFFFFF; ve = 32'd0; end
        4: begin va = 32'hFFFFFFFF; vb = 32'd1; ve = 32'd0; end
        5: begin vf3 = 3'd1; va = 32'd1; vb = 32'hFFFFFFE3; ve = 32'd8; end
        6: begin vf3 = 3'd5; va = 32'h80000000; vb = 32'd31; ve = 32'd1; end
        7: begin vf3 = 3'd6; va = 32'hF0F00000; vb = 32'h0000F0F0; ve = 32'hF0F0F0F0; end
        default: begin
          vf3 = 3'($urandom_range(0, 7));
          vf7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
          if (vf7 == 7'h20) vf3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
          va = $urandom; vb = $urandom;
          model(vf3, vf7, va, vb, ve, ee);
        end
      endcase
      exp_q.push_back(ve); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1);
      run32(vf3, vf7, va, vb, r, e, lat, rdy);
      er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
      total++;
      if (r !== er || e !== ee || lat !== el || rdy !== 1'b1) begin
        bad++;
        $display("FAIL basic[%0d] f3=%0d f7=%h: res=%h err=%b lat=%0d rdy=%b want %h %b %0d 1",
                 i, vf3, vf7, r, e, lat, rdy, er, ee, el);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    logic        e, rdy, stable;
    int          lat;
    // Hold the illegal result for 5 cycles with out_ready low.
    @(negedge clk);
    in_valid = 1'b1; f3 = 3'd0; f7 = 7'b0000010; rs1 = 32'd9; rs2 = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; rs1 = 32'hDEADBEEF;
    total++;
    if (out_valid !== 1'b1 || error !== 1'b1 || res !== 32'h0) begin
      bad++;
      $display("FAIL illegal_lat1: vld=%b err=%b res=%h want 1 1 00000000", out_valid, error, res);
    end
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || error !== 1'b1 || res !== 32'h0 || in_ready !== 1'b0) stable = 1'b0;
    end
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("FAIL illegal_hold: vld=%b err=%b res=%h rdy=%b want 1 1 00000000 0",
               out_valid, error, res, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL illegal_drain: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      logic [2:0] vf3;
      logic [6:0] vf7;
      case (i)
        0: begin vf3 = 3'd1; vf7 = 7'h20; end
        1: begin vf3 = 3'd7; vf7 = 7'h7F; end
        default: begin vf3 = 3'd0; vf7 = 7'h01; end
      endcase
`ifdef ALU_MULDIV_EN
      if (i == 2) break;
`endif
      exp_q.push_back(32'h0); exp_err_q.push_back(1'b1); exp_lat_q.push_back(1);
      run32(vf3, vf7, 32'h12345678, 32'h9ABCDEF0, r, e, lat, rdy);
      total++;
      if (r !== exp_q[0] || e !== exp_err_q[0] || lat !== exp_lat_q[0]) begin
        bad++;
        $display("FAIL illegal[%0d]: res=%h err=%b lat=%0d want %h %b %0d",
                 i, r, e, lat, exp_q[0], exp_err_q[0], exp_lat_q[0]);
      end
      void'(exp_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_lat_q.pop_front());
    end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv();
    logic [2:0]  vf3;
    logic [31:0] va, vb, ve, r, er;
    logic        e, rdy;
    int          lat, el;
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:  begin vf3 = 3'd4; va = 32'h80000000; vb = 32'hFFFFFFFF; ve = 32'h80000000; end
        1:  begin vf3 = 3'd5; va = 32'd7;        vb = 32'd0;        ve = 32'hFFFFFFFF; end
        2:  begin vf3 = 3'd6; va = 32'hFFFFFFF9; vb = 32'd2;        ve = 32'hFFFFFFFF; end
        3:  begin vf3 = 3'd3; va = 32'hFFFFFFFF; vb = 32'hFFFFFFFF; ve = 32'hFFFFFFFE; end
        4:  begin vf3 = 3'd0; va = 32'hFFFFFFFF; vb = 32'd3;        ve = 32'hFFFFFFFD; end
        5:  begin vf3 = 3'd1; va = 32'hFFFFFFFF; vb = 32'd3;        ve = 32'hFFFFFFFF; end
        6:  begin vf3 = 3'd2; va = 32'hFFFFFFFF; vb = 32'hFFFFFFFF; ve = 32'hFFFFFFFF; end
        7:  begin vf3 = 3'd4; va = 32'hFFFFFFF9; vb = 32'd2;        ve = 32'hFFFFFFFD; end
        8:  begin vf3 = 3'd7; va = 32'd100;      vb = 32'd7;        ve = 32'd2;        end
        9:  begin vf3 = 3'd6; va = 32'h80000000; vb = 32'hFFFFFFFF; ve = 32'd0;        end
        10: begin vf3 = 3'd4; va = 32'd5;        vb = 32'd0;        ve = 32'hFFFFFFFF; end
        default: begin vf3 = 3'd6; va = 32'hFFFFFFF9; vb = 32'd0;   ve = 32'hFFFFFFF9; end
      endcase
      exp_q.push_back(ve); exp_err_q.push_back(1'b0); exp_lat_q.push_back(MD_LAT);
      run32(vf3, 7'h01, va, vb, r, e, lat, rdy);
      er = exp_q.pop_front(); el = exp_lat_q.pop_front();
      total++;
      if (r !== er || e !== exp_err_q.pop_front() || lat !== el) begin
        bad++;
        $display("FAIL muldiv[%0d] f3=%0d: res=%h err=%b lat=%0d want %h 0 %0d",
                 i, vf3, r, e, lat, er, el);
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] r;
    logic        e, rdy, quiet;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1; f3 = 3'd0; rs1 = 32'h80000000; rs2 = 32'hFFFFFFFF;
`ifdef ALU_MULDIV_EN
    f3 = 3'd4; f7 = 7'h01;
`else
    f7 = 7'h00;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef ALU_MULDIV_EN
    repeat (9) @(posedge clk);
    #1;
`endif
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || error !== 1'b0 || res !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: rdy=%b vld=%b err=%b res=%h want 1 0 0 00000000",
               in_ready, out_valid, error, res);
    end
    @(negedge clk);
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_quiet: spurious vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    exp_q.push_back(32'd3); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1);
    run32(3'd0, 7'h00, 32'd1, 32'd2, r, e, lat, rdy);
    total++;
    if (r !== exp_q[0] || e !== exp_err_q[0] || lat !== exp_lat_q[0]) begin
      bad++;
      $display("FAIL reset_mid_add: res=%h err=%b lat=%0d want %h 0 1", r, e, lat, exp_q[0]);
    end
    void'(exp_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_lat_q.pop_front());
  endtask

  // in_valid and out_ready both held high: accepts and drains alternate,
  // because nothing is accepted in the draining cycle.
  task automatic test_back_to_back();
    logic [31:0] er;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; f3 = 3'd0; f7 = 7'h00; rs1 = 32'd100; rs2 = 32'd0;
    exp_q.push_back(32'd100);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      total++;
      if (k % 2 == 1) begin
        er = exp_q.pop_front();
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || res !== er) begin
          bad++;
          $display("FAIL b2b[%0d]: vld=%b rdy=%b res=%h want 1 0 %h", k, out_valid, in_ready, res, er);
        end
        rs2 = 32'(k);
      end else begin
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b[%0d]: vld=%b rdy=%b want 0 1", k, out_valid, in_ready);
        end
        if (k < 8) exp_q.push_back(32'd100 + rs2);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_xlen8();
    logic [7:0] r;
    logic       e;
    int         lat;
    run8(3'd0, 7'h00, 8'hFF, 8'h01, r, e, lat);
    total++;
    if (r !== 8'h00 || e !== 1'b0 || lat !== 1) begin
      bad++;
      $display("FAIL x8_add: res=%h err=%b lat=%0d want 00 0 1", r, e, lat);
    end
    run8(3'd1, 7'h00, 8'h01, 8'h0B, r, e, lat);
    total++;
    if (r !== 8'h08 || e !== 1'b0 || lat !== 1) begin
      bad++;
      $display("FAIL x8_sll: res=%h err=%b lat=%0d want 08 0 1", r, e, lat);
    end
    run8(3'd5, 7'h20, 8'h80, 8'h0F, r, e, lat);
    total++;
    if (r !== 8'hFF || e !== 1'b0 || lat !== 1) begin
      bad++;
      $display("FAIL x8_sra: res=%h err=%b lat=%0d want ff 0 1", r, e, lat);
    end
    run8(3'd0, 7'h01, 8'h03, 8'h05, r, e, lat);
    total++;
`ifdef ALU_MULDIV_EN
    if (r !== 8'h0F || e !== 1'b0 || lat !== 9) begin
      bad++;
      $display("FAIL x8_mul: res=%h err=%b lat=%0d want 0f 0 9", r, e, lat);
    end
`else
    if (r !== 8'h00 || e !== 1'b1 || lat !== 1) begin
      bad++;
      $display("FAIL x8_mul: res=%h err=%b lat=%0d want 00 1 1", r, e, lat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
`ifdef ALU_MULDIV_EN
    test_muldiv();
`endif
    test_reset_mid();
    test_back_to_back();
    test_xlen8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), width of the shift-amount field taken from the operand LSBs.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 subfunction_3  input  3  R-type funct3.
REQ-008 subfunction_7  input  7  R-type funct7.
REQ-009 input_register1_value  input  XLEN  rs1 operand.
REQ-010 input_register2_value  input  XLEN  rs2 operand.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result_to_write_rd  output  XLEN  rd result.
REQ-014 error  output  1  illegal encoding flag, qualified by out_valid.

Function
REQ-015 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept = in_valid && in_ready; operands, subfunction_3 and subfunction_7 SHALL be captured on accept and held internally, so input changes after accept have no effect.
REQ-017 funct7 0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND; funct7 0100000: SUB (rs1-rs2), SRA; results computed rs1 op rs2, modulo 2^XLEN.
REQ-018 Shifts SHALL use input_register2_value[SHAMT_W-1:0] only; SRA sign-fills from rs1 MSB.
REQ-019 SLT/SLTU SHALL return zero-extended 1 when rs1 < rs2 (signed/unsigned), else 0.
REQ-020 Basic ops: IDLE -> DONE on accept; out_valid SHALL assert the cycle after accept (latency 1).
REQ-021 Any other funct3/funct7 combination: IDLE -> DONE, error=1, result_to_write_rd=0, latency 1.
REQ-022 Legal results SHALL drive error=0.
REQ-023 DONE holds out_valid, result and error stable until out_ready=1; on out_valid && out_ready -> IDLE next cycle; no new accept in that same cycle.
REQ-024 BUSY iteration counter SHALL count exactly XLEN cycles, then -> DONE; muldiv latency = XLEN+1 cycles from accept to out_valid.
REQ-025 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1; error=0.
REQ-026 Signed overflow (most-negative / -1): DIV = rs1, REM = 0; error=0.
REQ-027 Signed DIV/REM SHALL round toward zero; remainder sign follows dividend.
REQ-028 MULH/MULHSU/MULHU return upper XLEN bits of the 2*XLEN product with signedness of RISC-V M; MUL returns lower XLEN bits.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, error=0, result_to_write_rd=0, iteration counter=0.
REQ-030 Reset asserted in BUSY or DONE SHALL abandon the operation; no out_valid after reset release until a new accept.
REQ-031 First accept SHALL be possible in the first rising edge with reset_n high.

Configuration
REQ-032 Macro ALU_MULDIV_EN defined: funct7 0000001 with funct3 000..111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, executed iteratively via BUSY.
REQ-033 ALU_MULDIV_EN undefined: funct7 0000001 SHALL be illegal per REQ-021, BUSY state and iteration datapath SHALL not be synthesised, all ops latency 1.

Verification
REQ-034 XLEN=32, SUB rs1=5, rs2=7 -> out_valid cycle after accept, result 0xFFFFFFFE, error=0.
REQ-035 SRA rs1=0x80000000, rs2=0x00000024 (shamt 4) -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; SLT same -> 0.
REQ-036 funct7=0000010, funct3=000 -> error=1, result 0, latency 1; hold out_ready=0 5 cycles -> outputs stable, in_ready=0.
REQ-037 ALU_MULDIV_EN: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 33 cycles; DIVU 7/0 -> 0xFFFFFFFF; REM -7/2 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-038 reset_n pulsed low during BUSY cycle 10 -> IDLE, out_valid=0, no spurious result; next ADD 1+2 -> 3.
REQ-039 XLEN=8 build without macro: ADD 0xFF+0x01 -> 0x00; SLL 0x01 by rs2=0x0B (shamt 3) -> 0x08; MUL encoding -> error=1.
